// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Holds the mdop encoding, the FSM states and small op classifiers.
package mdu_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } mdop_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } state_e;

    function automatic logic is_signed_op(input mdop_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic is_div_op(input mdop_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement negation (combinational).
// Ports: i_val value, i_neg negate when high, o_val result.
module mdu_negate
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_val,
    input  logic             i_neg,
    output logic [WIDTH-1:0] o_val
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    assign o_val = i_neg ? (~i_val + ONE) : i_val;

endmodule

// File: rtl/mdu_iter.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Ports: clk, reset (async low), startE/mdopE/srcaE/srcbE start an op,
// hiweW/loweW/wdataW MTHI/MTLO, flushE abort, hi/lo/busy/done status.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             startE,
    input  logic [1:0]       mdopE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             hiweW,
    input  logic             loweW,
    input  logic [WIDTH-1:0] wdataW,
    input  logic             flushE,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    state_e           r_state;
    state_e           w_next;
    logic [CW-1:0]    r_cnt;
    mdop_e            r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_hw;
    logic [WIDTH-1:0] r_lw;
    logic             r_neg_lo;
    logic             r_neg_hi;
    logic             r_dz;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;

    mdop_e              w_op;
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    assign w_op = mdop_e'(mdopE);
    assign w_sa = is_signed_op(w_op) & srcaE[WIDTH-1];
    assign w_sb = is_signed_op(w_op) & srcbE[WIDTH-1];

    mdu_negate #(.WIDTH(WIDTH)) u_abs_a (
        .i_val (srcaE),
        .i_neg (w_sa),
        .o_val (w_abs_a)
    );

    mdu_negate #(.WIDTH(WIDTH)) u_abs_b (
        .i_val (srcbE),
        .i_neg (w_sb),
        .o_val (w_abs_b)
    );

    // Multiply: r_hw is the running high half, r_lw the multiplier
    // shifting out to the right while product bits shift in.
    assign w_addend = r_lw[0] ? r_a : '0;
    assign w_sum    = {1'b0, r_hw} + {1'b0, w_addend};

    // Divide: r_hw is the partial remainder, r_lw the dividend shifting
    // out to the left while quotient bits shift in. Bit WIDTH of the
    // difference is the borrow, i.e. trial < divisor.
    assign w_trial = {r_hw, r_lw[WIDTH-1]};
    assign w_diff  = w_trial - {1'b0, r_a};
    assign w_ge    = ~w_diff[WIDTH];

    mdu_negate #(.WIDTH(2*WIDTH)) u_neg_prod (
        .i_val ({r_hw, r_lw}),
        .i_neg (r_neg_lo),
        .o_val (w_prod)
    );

    mdu_negate #(.WIDTH(WIDTH)) u_neg_quo (
        .i_val (r_lw),
        .i_neg (r_neg_lo),
        .o_val (w_quo)
    );

    mdu_negate #(.WIDTH(WIDTH)) u_neg_rem (
        .i_val (r_hw),
        .i_neg (r_neg_hi),
        .o_val (w_rem)
    );

    // With a zero divisor the remainder is the dividend magnitude, so
    // the sign fix restores srcaE; only the quotient needs forcing.
    assign w_res_hi = is_div_op(r_op) ? w_rem : w_prod[2*WIDTH-1:WIDTH];
    assign w_res_lo = is_div_op(r_op) ? (r_dz ? '1 : w_quo)
                                      : w_prod[WIDTH-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (startE && !flushE) w_next = S_RUN;
            S_RUN: begin
                if (flushE) begin
                    w_next = S_IDLE;
                end else if (r_cnt == CW'(WIDTH-1)) begin
                    w_next = S_FIX;
                end
            end
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_op     <= MD_MULT;
            r_a      <= '0;
            r_hw     <= '0;
            r_lw     <= '0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_dz     <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (hiweW) r_hi <= wdataW;
                    if (loweW) r_lo <= wdataW;
                    if (startE && !flushE) begin
                        r_op     <= w_op;
                        r_cnt    <= '0;
                        r_hw     <= '0;
                        r_a      <= is_div_op(w_op) ? w_abs_b : w_abs_a;
                        r_lw     <= is_div_op(w_op) ? w_abs_a : w_abs_b;
                        r_neg_lo <= w_sa ^ w_sb;
                        r_neg_hi <= w_sa;
                        r_dz     <= is_div_op(w_op) && (srcbE == '0);
                    end
                end
                S_RUN: begin
                    if (!flushE) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (is_div_op(r_op)) begin
                            r_hw <= w_ge ? w_diff[WIDTH-1:0]
                                         : w_trial[WIDTH-1:0];
                            r_lw <= {r_lw[WIDTH-2:0], w_ge};
                        end else begin
                            r_hw <= w_sum[WIDTH:1];
                            r_lw <= {w_sum[0], r_lw[WIDTH-1:1]};
                        end
                    end
                end
                S_FIX: begin
                    if (!flushE) begin
                        r_hi   <= w_res_hi;
                        r_lo   <= w_res_lo;
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign busy = (r_state != S_IDLE);
    assign done = r_done;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed and randomised self-checking bench for mdu_iter (WIDTH=32).
// Results are compared with constants and a behavioural model.
module tb_mdu_iter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         startE = 1'b0;
    logic [1:0]   mdopE = 2'b00;
    logic [W-1:0] srcaE = '0;
    logic [W-1:0] srcbE = '0;
    logic         hiweW = 1'b0;
    logic         loweW = 1'b0;
    logic [W-1:0] wdataW = '0;
    logic         flushE = 1'b0;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;

    int n_cmp = 0;
    int n_bad = 0;

    mdu_iter #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .startE (startE),
        .mdopE  (mdopE),
        .srcaE  (srcaE),
        .srcbE  (srcbE),
        .hiweW  (hiweW),
        .loweW  (loweW),
        .wdataW (wdataW),
        .flushE (flushE),
        .hi     (hi),
        .lo     (lo),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        startE = 1'b1;
        mdopE  = op;
        srcaE  = a;
        srcbE  = b;
    endtask

    // Counts edges until done; optionally re-asserts startE at edge
    // poke_k with other operands, which must be ignored.
    task automatic wait_done(input int poke_k, input int exp_lat);
        int k;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
            startE = 1'b0;
            hiweW  = 1'b0;
            loweW  = 1'b0;
            if (k == poke_k) launch(2'b01, 32'd2, 32'd3);
        end while (!done && k < 100);
        check("latency", 64'(k), 64'(exp_lat));
        @(posedge clk);
        #1;
        check("done_pulse", 64'(done), 64'd0);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int poke_k,
                          output logic [W-1:0] rh,
                          output logic [W-1:0] rl);
        launch(op, a, b);
        wait_done(poke_k, W + 2);
        rh = hi;
        rl = lo;
    endtask

    task automatic model(input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b,
                         output logic [W-1:0] mh,
                         output logic [W-1:0] ml);
        longint      sa;
        longint      sb;
        longint      sp;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op[1] && b == '0) begin
            ml = '1;
            mh = a;
        end else begin
            case (op)
                2'b00: begin
                    sp = sa * sb;
                    up = 64'(sp);
                    {mh, ml} = up;
                end
                2'b01: begin
                    up = {32'd0, a} * {32'd0, b};
                    {mh, ml} = up;
                end
                2'b10: begin
                    sp = sa / sb;
                    up = 64'(sp);
                    ml = up[W-1:0];
                    sp = sa % sb;
                    up = 64'(sp);
                    mh = up[W-1:0];
                end
                default: begin
                    ml = a / b;
                    mh = a % b;
                end
            endcase
        end
    endtask

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] eh;
        logic [W-1:0] el;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [W-1:0] rh;
        logic [W-1:0] rl;
        logic [W-1:0] mh;
        logic [W-1:0] ml;
        int           nd;
        int           nb;

        vecs[0] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF,
                    32'hFFFFFFFE, 32'h00000001};
        vecs[1] = '{2'b00, 32'hFFFFFFF9, 32'd3,
                    32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2] = '{2'b10, 32'hFFFFFFF9, 32'd2,
                    32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{2'b11, 32'h12345678, 32'd0,
                    32'h12345678, 32'hFFFFFFFF};
        vecs[4] = '{2'b10, 32'h80000000, 32'hFFFFFFFF,
                    32'h00000000, 32'h80000000};
        vecs[5] = '{2'b00, 32'hFFFFFFFD, 32'hFFFFFFFB,
                    32'h00000000, 32'h0000000F};
        vecs[6] = '{2'b10, 32'd7, 32'hFFFFFFFE,
                    32'h00000001, 32'hFFFFFFFD};
        vecs[7] = '{2'b01, 32'h12345678, 32'h10,
                    32'h00000001, 32'h23456780};
        vecs[8] = '{2'b11, 32'd100, 32'd7,
                    32'h00000002, 32'h0000000E};

        repeat (3) @(posedge clk);
        #1;
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b,
                   (i == 2) ? 6 : 0, rh, rl);
            check($sformatf("v%0d_hi", i), 64'(rh), 64'(vecs[i].eh));
            check($sformatf("v%0d_lo", i), 64'(rl), 64'(vecs[i].el));
        end

        // Flush in RUN cycle 10; a second start at cycle 5 is ignored.
        launch(2'b10, 32'd1000, 32'd3);
        nd = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            startE = 1'b0;
            if (k == 5) launch(2'b01, 32'd2, 32'd3);
            if (done) nd++;
        end
        flushE = 1'b1;
        @(posedge clk);
        #1;
        flushE = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_hi", 64'(hi), 64'h2);
        check("flush_lo", 64'(lo), 64'hE);
        nb = 0;
        repeat (W + 6) begin
            @(posedge clk);
            #1;
            if (done) nd++;
            if (busy) nb++;
        end
        check("flush_no_done", 64'(nd), 64'd0);
        check("flush_stays_idle", 64'(nb), 64'd0);

        // Asynchronous reset in RUN cycle 5.
        launch(2'b00, 32'hFFFFFFF9, 32'd3);
        repeat (5) begin
            @(posedge clk);
            #1;
            startE = 1'b0;
        end
        reset = 1'b0;
        #1;
        check("arst_hi", 64'(hi), 64'd0);
        check("arst_lo", 64'(lo), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        nd = 0;
        repeat (W + 4) begin
            @(posedge clk);
            #1;
            if (done) nd++;
        end
        check("arst_no_done", 64'(nd), 64'd0);

        hiweW  = 1'b1;
        wdataW = 32'hA5A5A5A5;
        @(posedge clk);
        #1;
        hiweW = 1'b0;
        check("mthi_idle", 64'(hi), 64'hA5A5A5A5);

        // MTLO while busy is dropped.
        launch(2'b01, 32'd4, 32'd5);
        @(posedge clk);
        #1;
        startE = 1'b0;
        loweW  = 1'b1;
        wdataW = 32'h77;
        @(posedge clk);
        #1;
        loweW = 1'b0;
        check("mtlo_busy", 64'(lo), 64'd0);
        wait_done(0, W);
        check("mul45_hi", 64'(hi), 64'd0);
        check("mul45_lo", 64'(lo), 64'd20);

        // MTHI together with start: write lands, result overwrites.
        launch(2'b01, 32'd2, 32'd3);
        hiweW  = 1'b1;
        wdataW = 32'hDEAD;
        @(posedge clk);
        #1;
        startE = 1'b0;
        hiweW  = 1'b0;
        check("mthi_start", 64'(hi), 64'hDEAD);
        check("start_busy", 64'(busy), 64'd1);
        wait_done(0, W + 1);
        check("ovw_hi", 64'(hi), 64'd0);
        check("ovw_lo", 64'(lo), 64'd6);

        for (int n = 0; n < 30; n++) begin
            logic [1:0]   op;
            logic [W-1:0] a;
            logic [W-1:0] b;
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = (n % 7 == 3) ? '0 : $urandom;
            if (n % 5 == 1) b = b >> $urandom_range(0, 31);
            model(op, a, b, mh, ml);
            run_op(op, a, b, 0, rh, rl);
            check($sformatf("rnd%0d_hi", n), 64'(rh), 64'(mh));
            check($sformatf("rnd%0d_lo", n), 64'(rl), 64'(ml));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand, HI and LO width; legal values are even numbers from 8 to 64.
REQ-002 The block SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, meaning an asynchronous, active-low reset.
REQ-004 The block SHALL have port startE, input, 1, meaning: begin the operation selected by mdopE using srcaE and srcbE.
REQ-005 The block SHALL have port mdopE, input, 2, meaning the operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 The block SHALL have port srcaE, input, WIDTH, meaning the multiplicand or dividend.
REQ-007 The block SHALL have port srcbE, input, WIDTH, meaning the multiplier or divisor.
REQ-008 The block SHALL have ports hiweW and loweW, input, 1 each, meaning MTHI and MTLO write enables.
REQ-009 The block SHALL have port wdataW, input, WIDTH, meaning the MTHI/MTLO write data.
REQ-010 The block SHALL have port flushE, input, 1, meaning: abort the operation in flight.
REQ-011 The block SHALL have ports hi and lo, output, WIDTH each, meaning the registered HI and LO values.
REQ-012 The block SHALL have port busy, output, 1, meaning an operation is in progress; the hazard unit stalls MFHI, MFLO, MTHI, MTLO and new mult/div instructions while busy is high.
REQ-013 The block SHALL have port done, output, 1, meaning a one-cycle pulse issued on the cycle after hi/lo take the result.

Function
REQ-014 The state machine SHALL have three states: IDLE, RUN and FIX.
REQ-015 On startE in IDLE, the block SHALL latch the operand magnitudes (absolute values for MULT/DIV, raw values for MULTU/DIVU) and the result signs, clear the step counter, and enter RUN.
REQ-016 RUN SHALL perform one radix-2 step per cycle for exactly WIDTH cycles: shift-add for multiply, restoring subtract-shift for divide.
REQ-017 After the counter reaches WIDTH-1, the block SHALL enter FIX, which applies sign correction and writes hi/lo on the FIX-to-IDLE edge.
REQ-018 done SHALL pulse in the first IDLE cycle, so the latency from the startE edge to done is WIDTH+2 cycles.
REQ-019 busy SHALL be high in RUN and FIX only.
REQ-020 For multiply, the result SHALL be the 2*WIDTH-bit product, with hi holding the upper half and lo the lower half; MULT negates the product when the operand signs differ.
REQ-021 For divide, lo SHALL hold the quotient, truncated toward zero, and hi SHALL hold the remainder, which takes the sign of the dividend.
REQ-022 On divide by zero, the block SHALL set lo to all ones and hi to srcaE, and SHALL keep the full latency.
REQ-023 For DIV with the most negative dividend and a divisor of -1, the block SHALL set lo to the most negative value and hi to 0.
REQ-024 startE while busy SHALL be ignored.
REQ-025 flushE SHALL have priority over startE in the same cycle.
REQ-026 flushE in RUN or FIX SHALL return the block to IDLE on the next edge, with hi/lo unchanged and no done pulse.
REQ-027 A hiweW or loweW write SHALL update hi or lo on the next edge only while in IDLE, and SHALL be ignored while busy.
REQ-028 When startE and hiweW/loweW are asserted in the same IDLE cycle, the write SHALL apply, and the later result SHALL overwrite both hi and lo.

Reset
REQ-029 Assertion of reset SHALL force IDLE, hi=0, lo=0, busy=0, done=0, the counter to 0 and all working registers to 0, asynchronously.
REQ-030 Reset asserted mid-operation SHALL discard the operation without a done pulse.
REQ-031 Deassertion of reset SHALL be treated as synchronous to clk by the integrating level.

Structure
REQ-032 Shared package mdu_pkg SHALL hold the mdop encoding enum (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU) and the state enum (S_IDLE, S_RUN, S_FIX).
REQ-033 One combinational sub-module, mdu_negate #(WIDTH), SHALL perform two's-complement conditional negation, instanced for the operand abs values, the product and the quotient/remainder correction.
REQ-034 The counter SHALL be $clog2(WIDTH) bits wide.
REQ-035 The block SHALL use no multiplier or divider operators.

Verification
REQ-036 MULTU with WIDTH=32, srcaE=0xFFFFFFFF and srcbE=0xFFFFFFFF -> done at start+34 cycles, hi=0xFFFFFFFE, lo=0x00000001.
REQ-037 MULT with srcaE=-7 and srcbE=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV with srcaE=-7 and srcbE=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-038 DIVU with srcbE=0 and srcaE=0x12345678 -> lo=0xFFFFFFFF, hi=0x12345678; DIV with 0x80000000 by 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-039 Start a DIV, assert flushE in RUN cycle 10 -> busy drops next cycle, no done pulse, hi/lo hold their prior values; a second startE issued during the original busy window is ignored.
REQ-040 Start a MULT, pulse reset low in RUN cycle 5 -> all outputs 0 immediately; then MTHI 0xA5A5A5A5 while idle -> hi=0xA5A5A5A5 next cycle, while MTLO during busy leaves lo unchanged.
REQ-041 WIDTH=8 and WIDTH=64 randomised runs of 10k operations against a reference model -> zero mismatches, with every done exactly WIDTH+2 cycles after its startE.
